// File: rtl/cp0_irq_controller_if.sv
// ---------------------------------------------------------------------------
// cp0_irq_controller_if
//   Register bus between software (master) and the CP0 interrupt controller
//   (slave). One access per cycle, no wait states.
//   bus_sel   : access strobe, one cycle per access
//   bus_we    : 1 = write, 0 = read (qualified by bus_sel)
//   bus_addr  : word index 0 PENDING, 1 ENABLE, 2 ROUTE, 3 CLAIM
//   bus_wdata : write data
//   bus_rdata : registered read data, holds until the next read
// ---------------------------------------------------------------------------
interface cp0_irq_controller_if;
   logic        bus_sel;
   logic        bus_we;
   logic [1:0]  bus_addr;
   logic [31:0] bus_wdata;
   logic [31:0] bus_rdata;

   modport master (output bus_sel, bus_we, bus_addr, bus_wdata, input bus_rdata);
   modport slave  (input bus_sel, bus_we, bus_addr, bus_wdata, output bus_rdata);
endinterface

// File: rtl/cp0_irq_controller.sv
// ---------------------------------------------------------------------------
// cp0_irq_controller
//   Source end of the CP0 external interrupt interface. Synchronises the
//   peripheral IRQ lines, latches pending state (edge or level per source),
//   masks it with ENABLE, routes each source to one of four lines and drives
//   irq[3:0] into CP0 interrupts[7:4].
//   clk     : system clock
//   reset   : asynchronous, active-low reset
//   src_irq : raw peripheral requests, asynchronous to clk
//   bus     : register bus (slave side)
//   irq     : registered level-high requests, irq[0] -> IP4 ... irq[3] -> IP7
// ---------------------------------------------------------------------------
module cp0_irq_controller #(
   parameter int                     NUM_SOURCES  = 8,
   parameter logic [NUM_SOURCES-1:0] EDGE_MASK    = '1,
   parameter logic [NUM_SOURCES-1:0] RESET_ENABLE = '0
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NUM_SOURCES-1:0] src_irq,
   cp0_irq_controller_if.slave    bus,
   output logic [3:0]             irq
);
   localparam int NS = NUM_SOURCES;

   logic [NS-1:0]   s1_q, s2_q, s3_q;
   logic [NS-1:0]   pend_q, pend_d;
   logic [NS-1:0]   en_q, en_d;
   logic [2*NS-1:0] route_q, route_d;
   logic [31:0]     rdata_q, rdata_d;
   logic [3:0]      irq_q, irq_d;
   logic [NS-1:0]   set_edge, w1c, hit;
   logic [31:0]     claim;
   logic            wr, rd;
   logic            unused_wdata;

   assign wr           = bus.bus_sel &  bus.bus_we;
   assign rd           = bus.bus_sel & ~bus.bus_we;
   assign set_edge     = s2_q & ~s3_q & EDGE_MASK;
   assign hit          = pend_q & en_q;
   assign unused_wdata = ^bus.bus_wdata;

   always_comb begin
      w1c     = '0;
      en_d    = en_q;
      route_d = route_q;
      if (wr) begin
         case (bus.bus_addr)
            2'd0:    w1c     = bus.bus_wdata[NS-1:0] & EDGE_MASK;
            2'd1:    en_d    = bus.bus_wdata[NS-1:0];
            2'd2:    route_d = bus.bus_wdata[2*NS-1:0];
            default: ;
         endcase
      end
      // Edge bits: set beats a same-cycle W1C. Level bits track the
      // synchronised line directly and ignore software.
      pend_d = (((pend_q & ~w1c) | set_edge) & EDGE_MASK) | (s2_q & ~EDGE_MASK);

      // Lowest index wins: scan downwards so the last hit assigned is the lowest.
      claim = '0;
      for (int i = NS - 1; i >= 0; i--)
         if (hit[i]) claim = {1'b1, 26'd0, 5'(i)};

      irq_d = '0;
      for (int i = 0; i < NS; i++)
         if (hit[i]) irq_d[route_q[2*i +: 2]] = 1'b1;

      // Reads return state from before this edge; no bypass of same-cycle writes.
      rdata_d = rdata_q;
      if (rd) begin
         case (bus.bus_addr)
            2'd0:    rdata_d = 32'(pend_q);
            2'd1:    rdata_d = 32'(en_q);
            2'd2:    rdata_d = 32'(route_q);
            default: rdata_d = claim;
         endcase
      end
   end

   // irq_q sits on the async reset so asserting reset drops irq immediately.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s1_q    <= '0;
         s2_q    <= '0;
         s3_q    <= '0;
         pend_q  <= '0;
         en_q    <= RESET_ENABLE;
         route_q <= '0;
         rdata_q <= '0;
         irq_q   <= '0;
      end else begin
         s1_q    <= src_irq;
         s2_q    <= s1_q;
         s3_q    <= s2_q;
         pend_q  <= pend_d;
         en_q    <= en_d;
         route_q <= route_d;
         rdata_q <= rdata_d;
         irq_q   <= irq_d;
      end
   end

   assign bus.bus_rdata = rdata_q;
   assign irq           = irq_q;
endmodule
